// File: rtl/r5fp_sqrt_round.sv
// Rounding/packing back end for the iterative square-root core: captures operand side-band on
// strobe_i, rounds the core's quotient on done_i and holds the result until the consumer takes it.
// Optional feature: define R5FP_SQRT_RMM_EN to give rnd_i=4 round-to-nearest, ties-away semantics.
module r5fp_sqrt_round #(
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned W      = FRAC_W + 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe_i,
  input  logic [EXP_W-1:0]          exp_i,
  input  logic                      spec_i,
  input  logic [EXP_W+FRAC_W:0]     spec_res_i,
  input  logic                      spec_nv_i,
  input  logic [2:0]                rnd_i,
  input  logic                      done_i,
  input  logic [W-1:0]              quo_i,
  input  logic [W-1:0]              rem_i,
  output logic                      ready_o,
  output logic [EXP_W+FRAC_W:0]     res_o,
  output logic                      nv_o,
  output logic                      nx_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  typedef enum logic [1:0] {StIdle, StWait, StFull} state_e;

  state_e                  state_q, state_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic                    spec_q, spec_d;
  logic [EXP_W+FRAC_W:0]   spec_res_q, spec_res_d;
  logic                    spec_nv_q, spec_nv_d;
  logic [2:0]              rnd_q, rnd_d;
  logic [EXP_W+FRAC_W:0]   res_q, res_d;
  logic                    nv_q, nv_d;
  logic                    nx_q, nx_d;
  logic                    valid_q, valid_d;

  logic                    guard, sticky, round_up, carry;
  logic [W-2:0]            mant_rnd;
  logic [EXP_W-1:0]        exp_rnd;
  logic [FRAC_W-1:0]       frac_rnd;

  // Rounding datapath on the live core outputs and the captured side-band.
  always_comb begin
    guard  = quo_i[1];
    sticky = quo_i[0] | (|rem_i);
    case (rnd_q)
      3'd1, 3'd2: round_up = 1'b0;
      3'd3:       round_up = guard | sticky;
`ifdef R5FP_SQRT_RMM_EN
      3'd4:       round_up = guard;
`endif
      default:    round_up = guard & (sticky | quo_i[2]);
    endcase
    mant_rnd = {1'b0, quo_i[W-1:2]} + {{(W-2){1'b0}}, round_up};
    // Integer part grew from 1 to 2: the fraction wrapped to zero.
    carry    = (mant_rnd[W-2:W-3] == 2'b10);
    exp_rnd  = exp_q + {{(EXP_W-1){1'b0}}, carry};
    frac_rnd = mant_rnd[FRAC_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_nv_d  = spec_nv_q;
    rnd_d      = rnd_q;
    res_d      = res_q;
    nv_d       = nv_q;
    nx_d       = nx_q;
    valid_d    = valid_q;
    unique case (state_q)
      StIdle: begin
        if (strobe_i) begin
          exp_d      = exp_i;
          spec_d     = spec_i;
          spec_res_d = spec_res_i;
          spec_nv_d  = spec_nv_i;
          rnd_d      = rnd_i;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (done_i) begin
          valid_d = 1'b1;
          state_d = StFull;
          if (spec_q) begin
            res_d = spec_res_q;
            nv_d  = spec_nv_q;
            nx_d  = 1'b0;
          end else begin
            res_d = {1'b0, exp_rnd, frac_rnd};
            nv_d  = 1'b0;
            nx_d  = guard | sticky;
          end
        end
      end
      StFull: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_nv_q  <= 1'b0;
      rnd_q      <= '0;
      res_q      <= '0;
      nv_q       <= 1'b0;
      nx_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_nv_q  <= spec_nv_d;
      rnd_q      <= rnd_d;
      res_q      <= res_d;
      nv_q       <= nv_d;
      nx_q       <= nx_d;
      valid_q    <= valid_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign res_o   = res_q;
  assign nv_o    = nv_q;
  assign nx_o    = nx_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_r5fp_sqrt_round.sv
// Self-checking bench for r5fp_sqrt_round (single precision): directed vectors, random operands
// against an arithmetic rounding model, backpressure and reset abort.
module tb_r5fp_sqrt_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe_i;
  logic [7:0]  exp_i;
  logic        spec_i;
  logic [31:0] spec_res_i;
  logic        spec_nv_i;
  logic [2:0]  rnd_i;
  logic        done_i;
  logic [25:0] quo_i;
  logic [25:0] rem_i;
  logic        ready_o;
  logic [31:0] res_o;
  logic        nv_o;
  logic        nx_o;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  r5fp_sqrt_round dut (
    .clk        (clk),
    .reset      (reset),
    .strobe_i   (strobe_i),
    .exp_i      (exp_i),
    .spec_i     (spec_i),
    .spec_res_i (spec_res_i),
    .spec_nv_i  (spec_nv_i),
    .rnd_i      (rnd_i),
    .done_i     (done_i),
    .quo_i      (quo_i),
    .rem_i      (rem_i),
    .ready_o    (ready_o),
    .res_o      (res_o),
    .nv_o       (nv_o),
    .nx_o       (nx_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk = ~clk;

  // Value = quo/4 (+ a tiny bit if rem != 0), mantissa in [1,2); round to 23 fraction bits.
  function automatic void model(input int unsigned e, input logic [25:0] quo,
                                input logic [25:0] rem, input int unsigned rnd,
                                output logic [31:0] res, output logic nx);
    longint unsigned q;
    int unsigned     low, mode, ee;
    bit              exact, tie, above, inc;
    logic [31:0]     qv, ev;
    q     = longint'(quo) / 4;
    low   = int'(quo % 4);
    exact = (low == 0) && (rem == 0);
    tie   = (low == 2) && (rem == 0);
    above = (low == 3) || ((low == 2) && (rem != 0));
    mode  = (rnd >= 5) ? 0 : rnd;
`ifndef R5FP_SQRT_RMM_EN
    if (mode == 4) mode = 0;
`endif
    case (mode)
      0:       inc = above || (tie && (q % 2 == 1));
      3:       inc = !exact;
      4:       inc = above || tie;
      default: inc = 1'b0;
    endcase
    q  = q + (inc ? 1 : 0);
    ee = e;
    if (q >= 64'd16777216) begin
      q  = q / 2;
      ee = ee + 1;
    end
    qv  = 32'(q);
    ev  = 32'(ee);
    res = {1'b0, ev[7:0], qv[22:0]};
    nx  = !exact;
  endfunction

  task automatic issue(input logic [7:0] e, input logic sp, input logic [31:0] sr,
                       input logic snv, input logic [2:0] r);
    strobe_i = 1'b1; exp_i = e; spec_i = sp; spec_res_i = sr; spec_nv_i = snv; rnd_i = r;
    @(posedge clk); #1;
    strobe_i = 1'b0; exp_i = '0; spec_i = 1'b0; spec_res_i = '0; spec_nv_i = 1'b0; rnd_i = '0;
  endtask

  task automatic pulse_done(input logic [25:0] q, input logic [25:0] rm);
    done_i = 1'b1; quo_i = q; rem_i = rm;
    @(posedge clk); #1;
    done_i = 1'b0; quo_i = '0; rem_i = '0;
  endtask

  task automatic test_reset;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || res_o !== 32'h0 || nv_o !== 1'b0 ||
        nx_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b res=%h nv=%b nx=%b, want 1 0 0 0 0",
               ready_o, valid_o, res_o, nv_o, nx_o);
    end
  endtask

  task automatic test_directed;
    logic [25:0] dq [5] = '{26'h2000000, 26'h2000002, 26'h2000002, 26'h3FFFFFE, 26'h2345678};
    logic [2:0]  dr [5] = '{3'd0, 3'd0, 3'd3, 3'd0, 3'd1};
    logic        ds [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] xr [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h40000000, 32'h7FC00000};
    logic        xx [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        xv [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(8'd127, ds[i], 32'h7FC00000, 1'b1, dr[i]);
      @(posedge clk); #1;
      done_i = 1'b1;
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early_valid: valid=%b, want 0", i, valid_o);
      end
      pulse_done(dq[i], 26'h0);
      checks++;
      if (valid_o !== 1'b1 || res_o !== xr[i] || nx_o !== xx[i] || nv_o !== xv[i]) begin
        errors++;
        $display("FAIL dir%0d: valid=%b res=%h nx=%b nv=%b, want 1 %h %b %b",
                 i, valid_o, res_o, nx_o, nv_o, xr[i], xx[i], xv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [25:0] q, rm;
    logic [7:0]  e;
    logic [2:0]  r;
    logic        sp, snv, xnx;
    logic [31:0] sr, xres;
    int unsigned dly;
    for (int i = 0; i < 300; i++) begin
      q   = 26'($urandom) | 26'h2000000;
      rm  = ($urandom_range(0, 2) == 0) ? 26'h0 : 26'($urandom);
      if ($urandom_range(0, 3) == 0) q[1:0] = 2'b10;
      e   = 8'($urandom_range(1, 254));
      r   = 3'($urandom_range(0, 7));
      sp  = ($urandom_range(0, 7) == 0);
      sr  = $urandom;
      snv = 1'($urandom);
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_ready: ready=%b, want 1", i, ready_o);
      end
      issue(e, sp, sr, snv, r);
      dly = $urandom_range(0, 3);
      for (int k = 0; k < int'(dly); k++) begin
        @(posedge clk); #1;
      end
      pulse_done(q, rm);
      if (sp) begin
        xres = sr; xnx = 1'b0;
      end else begin
        model(32'(e), q, rm, 32'(r), xres, xnx);
      end
      checks++;
      if (valid_o !== 1'b1 || res_o !== xres || nx_o !== xnx || nv_o !== (sp & snv)) begin
        errors++;
        $display("FAIL rnd%0d q=%h rem=%h e=%0d rnd=%0d sp=%b: valid=%b res=%h nx=%b nv=%b, want 1 %h %b %b",
                 i, q, rm, e, r, sp, valid_o, res_o, nx_o, nv_o, xres, xnx, sp & snv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    ready_i = 1'b0;
    issue(8'd127, 1'b0, 32'h0, 1'b0, 3'd3);
    pulse_done(26'h2000002, 26'h0);
    held = res_o;
    checks++;
    if (valid_o !== 1'b1 || held !== 32'h3F800001) begin
      errors++;
      $display("FAIL bp_first: valid=%b res=%h, want 1 3f800001", valid_o, held);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        strobe_i = 1'b1; exp_i = 8'd5; spec_i = 1'b1; spec_res_i = 32'hDEADBEEF; rnd_i = 3'd1;
      end
      checks++;
      if (ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready%0d: ready=%b, want 0", i, ready_o);
      end
      @(posedge clk); #1;
      strobe_i = 1'b0; exp_i = '0; spec_i = 1'b0; spec_res_i = '0; rnd_i = '0;
      checks++;
      if (valid_o !== 1'b1 || res_o !== held || nx_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b res=%h nx=%b, want 1 %h 1", i, valid_o, res_o, nx_o,
                 held);
      end
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, want 0 1", valid_o, ready_o);
    end
    // A done pulse in IDLE must not produce a result (the ignored strobe opened no operation).
    pulse_done(26'h2000000, 26'h0);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle_done: valid=%b ready=%b, want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_abort;
    issue(8'd127, 1'b0, 32'h0, 1'b0, 3'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulse_done(26'h2000000, 26'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
        errors++;
        $display("FAIL abort%0d: valid=%b ready=%b, want 0 1", i, valid_o, ready_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; strobe_i = 1'b0; exp_i = '0; spec_i = 1'b0; spec_res_i = '0; spec_nv_i = 1'b0;
    rnd_i = '0; done_i = 1'b0; quo_i = '0; rem_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
